// File: rtl/multicycle_sequencer_pkg.sv
// Shared constants for the multicycle sequencer: default widths, opcodes and FSM state codes.
package multicycle_sequencer_pkg;

   localparam int unsigned DefPcW     = 10;
   localparam int unsigned DefOffW    = 8;
   localparam int unsigned DefCntW    = 16;
   localparam int unsigned DefTimeout = 15;

   localparam logic [3:0] OpAdd  = 4'h0;
   localparam logic [3:0] OpLb   = 4'h1;
   localparam logic [3:0] OpSb   = 4'h2;
   localparam logic [3:0] OpBeq  = 4'h3;
   localparam logic [3:0] OpBne  = 4'h4;
   localparam logic [3:0] OpHalt = 4'hf;

   typedef logic [2:0] seq_state_t;

   localparam seq_state_t StIdle   = 3'd0;
   localparam seq_state_t StFetch  = 3'd1;
   localparam seq_state_t StDecode = 3'd2;
   localparam seq_state_t StExec   = 3'd3;
   localparam seq_state_t StMem    = 3'd4;
   localparam seq_state_t StWb     = 3'd5;
   localparam seq_state_t StDone   = 3'd6;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Decoder/datapath-facing bundle of the sequencer; master is the sequencer side.
interface multicycle_sequencer_if
   import multicycle_sequencer_pkg::*;
#(
   parameter int unsigned PC_W  = DefPcW,
   parameter int unsigned OFF_W = DefOffW,
   parameter int unsigned CNT_W = DefCntW
);
   logic             start;
   logic [PC_W-1:0]  start_addr;
   logic             branch;
   logic             mem_read;
   logic             mem_write;
   logic             halt;
   logic             branch_taken;
   logic [OFF_W-1:0] branch_off;
   logic             dmem_ack;

   logic [PC_W-1:0]  pc;
   logic             imem_en;
   logic             ir_load;
   logic             dmem_req;
   logic             dmem_we;
   logic             reg_wr_en;
   logic             done;
   logic             fault;
   logic [CNT_W-1:0] cycle_cnt;

   modport master (
      input  start, start_addr, branch, mem_read, mem_write, halt, branch_taken, branch_off,
             dmem_ack,
      output pc, imem_en, ir_load, dmem_req, dmem_we, reg_wr_en, done, fault, cycle_cnt
   );

   modport slave (
      output start, start_addr, branch, mem_read, mem_write, halt, branch_taken, branch_off,
             dmem_ack,
      input  pc, imem_en, ir_load, dmem_req, dmem_we, reg_wr_en, done, fault, cycle_cnt
   );
endinterface

// File: rtl/multicycle_sequencer_pc_unit.sv
// Program counter: load on start, +1 or signed-offset advance in writeback, wraps mod 2^PC_W.
module pc_unit #(
   parameter int unsigned PC_W  = 10,
   parameter int unsigned OFF_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [PC_W-1:0]  load_addr,
   input  logic             advance,
   input  logic             take_branch,
   input  logic [OFF_W-1:0] offset,
   output logic [PC_W-1:0]  pc
);
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] step;

   // Sign-extending size cast; the add then wraps naturally at PC_W bits.
   assign step = take_branch ? PC_W'($signed(offset)) : PC_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= '0;
      end else if (load) begin
         pc_q <= load_addr;
      end else if (advance) begin
         pc_q <= pc_q + step;
      end
   end

   assign pc = pc_q;
endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with cycle counter.
// Optional MEM watchdog enabled by defining MEM_TIMEOUT_EN.
module multicycle_sequencer
   import multicycle_sequencer_pkg::*;
#(
   parameter int unsigned PC_W  = DefPcW,
   parameter int unsigned OFF_W = DefOffW,
   parameter int unsigned CNT_W = DefCntW
`ifdef MEM_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT = DefTimeout
`endif
) (
   input logic                   clk,
   input logic                   reset,
   multicycle_sequencer_if.master bus
);
   seq_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             load_start;
   logic             counting;
   logic             to_fault;
   logic [PC_W-1:0]  pc;

   assign load_start = bus.start && (state_q == StIdle || state_q == StDone);
   assign counting   = (state_q != StIdle) && (state_q != StDone);

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned WdW = $clog2(TIMEOUT + 1);
   logic [WdW-1:0] wd_q;
   logic           fault_q;

   // Held at zero outside MEM, so every MEM entry starts a fresh count.
   always_ff @(posedge clk) begin
      if (reset || state_q != StMem) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_q + 1'b1;
      end
   end

   assign to_fault = (state_q == StMem) && !bus.dmem_ack && (wd_q == WdW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset || load_start) begin
         fault_q <= 1'b0;
      end else if (to_fault) begin
         fault_q <= 1'b1;
      end
   end

   assign bus.fault = fault_q;
`else
   assign to_fault  = 1'b0;
   assign bus.fault = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle, StDone: if (bus.start) state_d = StFetch;
         StFetch:        state_d = StDecode;
         StDecode:       state_d = StExec;
         StExec: begin
            if (bus.halt) begin
               state_d = StDone;
            end else if (bus.mem_read || bus.mem_write) begin
               state_d = StMem;
            end else begin
               state_d = StWb;
            end
         end
         StMem: begin
            if (bus.dmem_ack) begin
               state_d = StWb;
            end else if (to_fault) begin
               state_d = StDone;
            end
         end
         StWb:           state_d = StFetch;
         default:        state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || load_start) begin
         cnt_q <= '0;
      end else if (counting && cnt_q != {CNT_W{1'b1}}) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   pc_unit #(
      .PC_W (PC_W),
      .OFF_W(OFF_W)
   ) u_pc (
      .clk        (clk),
      .reset      (reset),
      .load       (load_start),
      .load_addr  (bus.start_addr),
      .advance    (state_q == StWb),
      .take_branch(bus.branch && bus.branch_taken),
      .offset     (bus.branch_off),
      .pc         (pc)
   );

   assign bus.pc        = pc;
   assign bus.cycle_cnt = cnt_q;
   assign bus.imem_en   = (state_q == StFetch);
   assign bus.ir_load   = (state_q == StFetch);
   assign bus.dmem_req  = (state_q == StMem);
   assign bus.dmem_we   = (state_q == StMem) && bus.mem_write;
   assign bus.reg_wr_en = (state_q == StWb) && !bus.branch && !bus.mem_write;
   assign bus.done      = (state_q == StDone);
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench: an instruction-level model predicts every output each cycle.
module tb_multicycle_sequencer;
   localparam int PC_W  = 10;
   localparam int OFF_W = 8;
   localparam int CNT_W = 8;
   localparam int PCM   = 1 << PC_W;
   localparam int CMAX  = (1 << CNT_W) - 1;
   localparam int TMO   = 15;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   multicycle_sequencer_if #(.PC_W(PC_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) bus ();

   multicycle_sequencer #(.PC_W(PC_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Model state: architectural PC, cycle count, fault flag and expected strobes.
   int m_pc, m_cnt;
   bit m_fault;
   bit e_imem, e_req, e_we, e_wr, e_done;

   task automatic cmp(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("pc", int'(bus.pc), m_pc);
         cmp("cycle_cnt", int'(bus.cycle_cnt), m_cnt);
         cmp("imem_en", int'(bus.imem_en), int'(e_imem));
         cmp("ir_load", int'(bus.ir_load), int'(e_imem));
         cmp("dmem_req", int'(bus.dmem_req), int'(e_req));
         cmp("dmem_we", int'(bus.dmem_we), int'(e_we));
         cmp("reg_wr_en", int'(bus.reg_wr_en), int'(e_wr));
         cmp("done", int'(bus.done), int'(e_done));
         cmp("fault", int'(bus.fault), int'(m_fault));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_exp(input bit imem, input bit req, input bit we, input bit wr, input bit dn);
      e_imem = imem;
      e_req  = req;
      e_we   = we;
      e_wr   = wr;
      e_done = dn;
   endtask

   task automatic bump();
      m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
   endtask

   task automatic noise();
      bus.start    = 1'($urandom_range(0, 1));
      bus.dmem_ack = 1'($urandom_range(0, 1));
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      bus.start = 1'b0;
      bus.start_addr = '0;
      {bus.branch, bus.mem_read, bus.mem_write, bus.halt, bus.branch_taken} = '0;
      bus.branch_off = '0;
      bus.dmem_ack = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      m_pc = 0;
      m_cnt = 0;
      m_fault = 1'b0;
      set_exp(0, 0, 0, 0, 0);
      chk_en = 1'b1;
   endtask

   task automatic launch(input int addr);
      bus.start = 1'b1;
      bus.start_addr = PC_W'(addr);
      tick();
      bus.start = 1'b0;
      bus.start_addr = PC_W'($urandom);
      m_pc = addr;
      m_cnt = 0;
      m_fault = 1'b0;
   endtask

   // One instruction from FETCH; returns positioned at the next FETCH (or DONE/IDLE).
   task automatic instr(input bit halt, input bit br, input bit mr, input bit mw, input bit taken,
                        input int off, input int ack_dly, input int rst_at);
      int i;
      bit ack;
      bus.halt = halt;
      bus.branch = br;
      bus.mem_read = mr;
      bus.mem_write = mw;
      bus.branch_taken = taken;
      bus.branch_off = OFF_W'(off);
      set_exp(1, 0, 0, 0, 0);
      noise();
      tick(); bump();
      set_exp(0, 0, 0, 0, 0);
      noise();
      tick(); bump();
      noise();
      if (halt) begin
         tick(); bump();
         bus.start = 1'b0;
         set_exp(0, 0, 0, 0, 1);
         return;
      end
      tick(); bump();
      if (mr || mw) begin
         i = 0;
         while (1) begin
            ack = (i >= ack_dly);
            bus.start = 1'($urandom_range(0, 1));
            bus.dmem_ack = ack;
            set_exp(0, 1, mw, 0, 0);
            if (i == rst_at) begin
               reset = 1'b1;
               tick();
               reset = 1'b0;
               bus.start = 1'b0;
               m_pc = 0;
               m_cnt = 0;
               m_fault = 1'b0;
               set_exp(0, 0, 0, 0, 0);
               return;
            end
`ifdef MEM_TIMEOUT_EN
            if (!ack && i == TMO - 1) begin
               tick(); bump();
               bus.start = 1'b0;
               m_fault = 1'b1;
               set_exp(0, 0, 0, 0, 1);
               return;
            end
`endif
            tick(); bump();
            if (ack) break;
            i++;
         end
      end
      set_exp(0, 0, 0, !br && !mw, 0);
      noise();
      tick(); bump();
      bus.start = 1'b0;
      if (br && taken) begin
         m_pc = (m_pc + off) % PCM;
         if (m_pc < 0) m_pc += PCM;
      end else begin
         m_pc = (m_pc + 1) % PCM;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got still running want finished");
      $fatal(1);
   end

   initial begin
      int n, kind;
      bit mr, mw, br;

      reset_dut();
      cmp("rst_pc", int'(bus.pc), 0);
      cmp("rst_done", int'(bus.done), 0);

      // ADD then HALT from 5.
      launch(5);
      cmp("t1_imem_c1", int'(bus.imem_en), 1);
      cmp("t1_pc5", int'(bus.pc), 5);
      instr(0, 0, 0, 0, 0, 0, 0, -1);
      cmp("t1_imem_c5", int'(bus.imem_en), 1);
      cmp("t1_pc6", int'(bus.pc), 6);
      instr(1, 0, 0, 0, 0, 0, 0, -1);
      cmp("t1_done", int'(bus.done), 1);
      cmp("t1_cnt7", int'(bus.cycle_cnt), 7);

      // LB with three wait cycles.
      launch(40);
      instr(0, 0, 1, 0, 0, 0, 3, -1);
      cmp("lb_cnt8", int'(bus.cycle_cnt), 8);
      cmp("lb_pc", int'(bus.pc), 41);
      instr(1, 0, 0, 0, 0, 0, 0, -1);

      // BNE taken and not taken from 20.
      launch(20);
      instr(0, 1, 0, 0, 1, -4, 0, -1);
      cmp("bne_taken_pc", int'(bus.pc), 16);
      instr(1, 0, 0, 0, 0, 0, 0, -1);
      launch(20);
      instr(0, 1, 0, 0, 0, -4, 0, -1);
      cmp("bne_not_taken_pc", int'(bus.pc), 21);
      instr(1, 0, 0, 0, 0, 0, 0, -1);

      // PC wrap, then a read+write treated as a store.
      launch(1023);
      instr(0, 0, 0, 0, 1, 7, 0, -1);
      cmp("wrap_pc", int'(bus.pc), 0);
      instr(0, 0, 1, 1, 0, 0, 0, -1);
      cmp("rw_pc", int'(bus.pc), 1);
`ifndef MEM_TIMEOUT_EN
      instr(0, 0, 1, 0, 0, 0, 20, -1);
`endif
      instr(1, 1, 1, 1, 1, 3, 0, -1);

      // Reset while stalled in MEM.
      launch(100);
      instr(0, 0, 1, 0, 0, 0, 999, 2);
      cmp("rstmem_req", int'(bus.dmem_req), 0);
      cmp("rstmem_pc", int'(bus.pc), 0);
      cmp("rstmem_cnt", int'(bus.cycle_cnt), 0);
      tick();
      cmp("rstmem_idle", int'(bus.imem_en), 0);

`ifdef MEM_TIMEOUT_EN
      launch(7);
      instr(0, 0, 1, 0, 0, 0, 999, -1);
      cmp("tmo_fault", int'(bus.fault), 1);
      cmp("tmo_done", int'(bus.done), 1);
      cmp("tmo_cnt", int'(bus.cycle_cnt), 3 + TMO);
      launch(9);
      cmp("tmo_fault_clr", int'(bus.fault), 0);
      instr(1, 0, 0, 0, 0, 0, 0, -1);
`endif

      // Counter saturation.
      launch(0);
      for (int k = 0; k < 70; k++) instr(0, 0, 0, 0, 0, 0, 0, -1);
      instr(1, 0, 0, 0, 0, 0, 0, -1);
      cmp("sat_cnt", int'(bus.cycle_cnt), CMAX);

      // Random programs.
      for (int p = 0; p < 25; p++) begin
         launch(int'($urandom_range(0, PCM - 1)));
         n = int'($urandom_range(1, 8));
         for (int k = 0; k < n; k++) begin
            kind = int'($urandom_range(0, 4));
            mr = (kind == 1) || (kind == 3);
            mw = (kind == 2) || (kind == 3);
            br = (kind == 4);
            instr(0, br, mr, mw, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 5)), -1);
         end
         instr(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 5, 0, -1);
         repeat ($urandom_range(0, 3)) tick();
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
